// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, functs,
// ALU operation codes and FSM state encoding.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXEC_R, WB_R, EXEC_I, WB_I, ILLEGAL
  } state_t;

endpackage

// File: rtl/alu_control.sv
// Combinational opcode/funct to ALU operation decode; legal flags any
// opcode or R-type funct the controller does not support.
module alu_control
  import mips_ctrl_pkg::*;
#(
  parameter int ALU_OP_W = 4
) (
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                legal
);

  always_comb begin
    alu_op = '0;
    legal  = 1'b1;
    case (opcode)
      OP_LW, OP_SW, OP_ADDI: alu_op = ALU_OP_W'(ALU_ADD);
      OP_ANDI:               alu_op = ALU_OP_W'(ALU_AND);
      OP_ORI:                alu_op = ALU_OP_W'(ALU_OR);
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  alu_op = ALU_OP_W'(ALU_ADD);
          FN_SUB:  alu_op = ALU_OP_W'(ALU_SUB);
          FN_AND:  alu_op = ALU_OP_W'(ALU_AND);
          FN_OR:   alu_op = ALU_OP_W'(ALU_OR);
          FN_SLT:  alu_op = ALU_OP_W'(ALU_SLT);
          default: legal  = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Moore-style multicycle MIPS control FSM with retired-instruction counter.
// Supports lw, sw, R-type add/sub/and/or/slt, addi, andi, ori.
module mips_multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int ALU_OP_W = 4,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                instr_valid,
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  output logic                IRWrite,
  output logic                PCWrite,
  output logic                RegWrite,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                MemtoReg,
  output logic                ALUSrc,
  output logic                RegDst,
  output logic [ALU_OP_W-1:0] ALU_OP,
  output logic                instr_done,
  output logic                illegal,
  output logic [CNT_W-1:0]    retired_cnt
);

  state_t                state, state_nxt;
  logic [5:0]            op_q, fn_q;
  logic [5:0]            dec_op, dec_fn;
  logic [ALU_OP_W-1:0]   dec_alu;
  logic                  dec_legal;

  // In DECODE the live instruction fields are checked; afterwards the
  // latched copy drives the ALU decode so outputs depend on state only.
  assign dec_op = (state == DECODE) ? opcode : op_q;
  assign dec_fn = (state == DECODE) ? funct  : fn_q;

  alu_control #(.ALU_OP_W(ALU_OP_W)) u_alu_control (
    .opcode (dec_op),
    .funct  (dec_fn),
    .alu_op (dec_alu),
    .legal  (dec_legal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FETCH;
      op_q        <= '0;
      fn_q        <= '0;
      retired_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == DECODE) begin
        op_q <= opcode;
        fn_q <= funct;
      end
      if (instr_done) retired_cnt <= retired_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:  if (instr_valid) state_nxt = DECODE;
      DECODE: begin
        if (!dec_legal)                           state_nxt = ILLEGAL;
        else if (opcode == OP_LW || opcode == OP_SW) state_nxt = MEMADR;
        else if (opcode == OP_RTYPE)              state_nxt = EXEC_R;
        else                                      state_nxt = EXEC_I;
      end
      MEMADR: state_nxt = (op_q == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  state_nxt = MEMWB;
      EXEC_R: state_nxt = WB_R;
      EXEC_I: state_nxt = WB_I;
      default: state_nxt = FETCH;
    endcase
  end

  always_comb begin
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    RegWrite   = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    MemtoReg   = 1'b0;
    ALUSrc     = 1'b0;
    RegDst     = 1'b0;
    ALU_OP     = '0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (state)
      // rst gating keeps IRWrite low while reset holds the FSM in FETCH.
      FETCH:  IRWrite = instr_valid & ~rst;
      MEMADR: begin
        ALUSrc = 1'b1;
        ALU_OP = ALU_OP_W'(ALU_ADD);
      end
      MEMRD: begin
        ALUSrc  = 1'b1;
        ALU_OP  = ALU_OP_W'(ALU_ADD);
        MemRead = 1'b1;
      end
      MEMWB: begin
        MemRead    = 1'b1;
        MemtoReg   = 1'b1;
        RegWrite   = 1'b1;
        ALUSrc     = 1'b1;
        ALU_OP     = ALU_OP_W'(ALU_ADD);
        PCWrite    = 1'b1;
        instr_done = 1'b1;
      end
      MEMWR: begin
        MemWrite   = 1'b1;
        ALUSrc     = 1'b1;
        ALU_OP     = ALU_OP_W'(ALU_ADD);
        PCWrite    = 1'b1;
        instr_done = 1'b1;
      end
      EXEC_R: begin
        RegDst = 1'b1;
        ALU_OP = dec_alu;
      end
      WB_R: begin
        RegDst     = 1'b1;
        ALU_OP     = dec_alu;
        RegWrite   = 1'b1;
        PCWrite    = 1'b1;
        instr_done = 1'b1;
      end
      EXEC_I: begin
        ALUSrc = 1'b1;
        ALU_OP = dec_alu;
      end
      WB_I: begin
        ALUSrc     = 1'b1;
        ALU_OP     = dec_alu;
        RegWrite   = 1'b1;
        PCWrite    = 1'b1;
        instr_done = 1'b1;
      end
      ILLEGAL: begin
        illegal = 1'b1;
        PCWrite = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for mips_multicycle_control: per-cycle control vectors from
// an independent table model, retirement/illegal pulses scored via a queue.
module tb_mips_multicycle_control;

  localparam int TB_CW = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             instr_valid;
  logic [5:0]       opcode, funct;
  logic             IRWrite, PCWrite, RegWrite, MemRead, MemWrite, MemtoReg;
  logic             ALUSrc, RegDst, instr_done, illegal;
  logic [3:0]       ALU_OP;
  logic [TB_CW-1:0] retired_cnt;
  logic [13:0]      dut_vec;

  typedef struct {
    logic             ill;
    int               lat;
    logic [TB_CW-1:0] cnt;
  } exp_t;

  exp_t             sb[$];
  logic [TB_CW-1:0] cnt_m;
  int               checks = 0;
  int               errors = 0;

  always #5 clk = ~clk;

  mips_multicycle_control #(.ALU_OP_W(4), .CNT_W(TB_CW)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .opcode(opcode), .funct(funct),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .ALUSrc(ALUSrc), .RegDst(RegDst),
    .ALU_OP(ALU_OP), .instr_done(instr_done), .illegal(illegal), .retired_cnt(retired_cnt)
  );

  assign dut_vec = {IRWrite, PCWrite, RegWrite, MemRead, MemWrite, MemtoReg,
                    ALUSrc, RegDst, ALU_OP, instr_done, illegal};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // class: 0 lw, 1 sw, 2 R-type, 3 I-type, 4 unsupported
  function automatic int cls_of(input logic [5:0] op, input logic [5:0] f, output logic [3:0] aop);
    aop = 4'b0010;
    case (op)
      6'b100011: return 0;
      6'b101011: return 1;
      6'b001000: return 3;
      6'b001100: begin aop = 4'b0000; return 3; end
      6'b001101: begin aop = 4'b0001; return 3; end
      6'b000000: begin
        case (f)
          6'b100000: aop = 4'b0010;
          6'b100010: aop = 4'b0110;
          6'b100100: aop = 4'b0000;
          6'b100101: aop = 4'b0001;
          6'b101010: aop = 4'b0111;
          default:   return 4;
        endcase
        return 2;
      end
      default: return 4;
    endcase
  endfunction

  function automatic int lat_of(input logic [5:0] op, input logic [5:0] f);
    logic [3:0] a;
    int c;
    c = cls_of(op, f, a);
    return (c == 0) ? 5 : (c == 4) ? 3 : 4;
  endfunction

  function automatic logic [13:0] exp_vec(input logic [5:0] op, input logic [5:0] f, input int k);
    logic ir, pc, rw, mr, mw, m2r, as, rd, dn, il;
    logic [3:0] a, aop;
    int c;
    {ir, pc, rw, mr, mw, m2r, as, rd, dn, il} = '0;
    a = 4'b0000;
    c = cls_of(op, f, aop);
    if (k == 1) ir = 1'b1;
    else if (k == 3) begin
      case (c)
        0, 1: begin as = 1'b1; a = 4'b0010; end
        2:    begin rd = 1'b1; a = aop; end
        3:    begin as = 1'b1; a = aop; end
        default: begin il = 1'b1; pc = 1'b1; end
      endcase
    end else if (k == 4) begin
      case (c)
        0: begin as = 1'b1; a = 4'b0010; mr = 1'b1; end
        1: begin mw = 1'b1; as = 1'b1; a = 4'b0010; pc = 1'b1; dn = 1'b1; end
        2: begin rd = 1'b1; a = aop; rw = 1'b1; pc = 1'b1; dn = 1'b1; end
        3: begin as = 1'b1; a = aop; rw = 1'b1; pc = 1'b1; dn = 1'b1; end
        default: ;
      endcase
    end else if (k == 5 && c == 0) begin
      mr = 1'b1; m2r = 1'b1; rw = 1'b1; as = 1'b1; a = 4'b0010; pc = 1'b1; dn = 1'b1;
    end
    return {ir, pc, rw, mr, mw, m2r, as, rd, a, dn, il};
  endfunction

  task automatic run_instr(input logic [5:0] op, input logic [5:0] f, input logic keep_valid);
    exp_t e, got;
    e.lat = lat_of(op, f);
    e.ill = (e.lat == 3);
    if (!e.ill) cnt_m = cnt_m + 1'b1;
    e.cnt = cnt_m;
    sb.push_back(e);
    for (int k = 1; k <= e.lat; k++) begin
      @(negedge clk);
      if (k == 1) begin instr_valid = 1'b1; opcode = op; funct = f; end
      else instr_valid = keep_valid;
      #1;
      chk($sformatf("ctrl op=%b fn=%b cyc%0d", op, f, k), 32'(dut_vec), 32'(exp_vec(op, f, k)));
      if (instr_done || illegal) begin
        chk("pulse_pending", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          got = sb.pop_front();
          chk($sformatf("latency op=%b fn=%b", op, f), k, got.lat);
          chk("pulse_kind", 32'(illegal), 32'(got.ill));
        end
      end
    end
    @(negedge clk);
    instr_valid = 1'b0;
    #1;
    chk("pulse_missing", sb.size(), 0);
    sb.delete();
    chk("back_in_fetch_idle", 32'(dut_vec), 0);
    chk("retired_cnt", 32'(retired_cnt), 32'(e.cnt));
  endtask

  initial begin
    logic [5:0] ops[6];
    logic [5:0] fns[6];
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000000, 6'b001101, 6'b001100};
    fns = '{6'b000000, 6'b000000, 6'b100000, 6'b100101, 6'b000000, 6'b000000};
    cnt_m = '0;
    rst = 1'b1; instr_valid = 1'b1; opcode = 6'b100011; funct = 6'b0;
    #7;
    chk("reset_outputs", 32'(dut_vec), 0);
    chk("reset_cnt", 32'(retired_cnt), 0);
    @(negedge clk);
    rst = 1'b0; instr_valid = 1'b0;

    run_instr(6'b100011, 6'b000000, 1'b0);  // lw
    run_instr(6'b101011, 6'b000000, 1'b0);  // sw
    run_instr(6'b000000, 6'b100010, 1'b0);  // sub
    run_instr(6'b000000, 6'b101010, 1'b1);  // slt, instr_valid held high
    run_instr(6'b000000, 6'b100100, 1'b0);  // and
    run_instr(6'b001000, 6'b010101, 1'b1);  // addi
    run_instr(6'b001100, 6'b000000, 1'b0);  // andi
    run_instr(6'b001101, 6'b000000, 1'b0);  // ori
    run_instr(6'b111111, 6'b100000, 1'b0);  // bad opcode
    run_instr(6'b000000, 6'b000111, 1'b0);  // bad funct

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      instr_valid = 1'b0;
      #1;
      chk("hold_fetch_idle", 32'(dut_vec), 0);
      chk("hold_cnt", 32'(retired_cnt), 32'(cnt_m));
    end
    run_instr(6'b000000, 6'b100000, 1'b0);

    // Reset while lw sits in MEMRD.
    @(negedge clk); instr_valid = 1'b1; opcode = 6'b100011; funct = 6'b0;
    @(negedge clk); instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    chk("pre_reset_memrd", 32'(dut_vec), 32'(exp_vec(6'b100011, 6'b0, 4)));
    #2 rst = 1'b1;
    #1;
    chk("async_reset_outputs", 32'(dut_vec), 0);
    chk("async_reset_cnt", 32'(retired_cnt), 0);
    @(negedge clk); #1;
    chk("reset_held_outputs", 32'(dut_vec), 0);
    rst = 1'b0;
    cnt_m = '0;
    run_instr(6'b001000, 6'b000000, 1'b0);  // addi after reset

    for (int i = 1; i < (1 << TB_CW); i++)
      run_instr(ops[i % 6], fns[i % 6], 1'b0);
    chk("cnt_wrapped_zero", 32'(retired_cnt), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
